// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: FSM states,
// instruction classes, opcode/funct encodings and ALU operation codes.
// Optional feature macro: UNIDAD_CONTROL_TRAP_EN adds the TRAP state.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
`ifdef UNIDAD_CONTROL_TRAP_EN
    ,
    S_TRAP = 3'd5
`endif
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE    = 3'd0,
    CL_RTYPE   = 3'd1,
    CL_LW      = 3'd2,
    CL_SW      = 3'd3,
    CL_ILLEGAL = 3'd4
  } class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Map an opcode onto the instruction class the FSM sequences by
  function automatic class_t decode_class(input logic [5:0] op);
    case (op)
      OP_RTYPE: decode_class = CL_RTYPE;
      OP_LW:    decode_class = CL_LW;
      OP_SW:    decode_class = CL_SW;
      default:  decode_class = CL_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/decod_alu.sv
// Combinational funct -> ALU operation decoder. Unknown funct codes
// fall back to ADD and report valid=0 so the caller can suppress writeback.
module decod_alu
  import ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       valid
);

  // Translate the R-type funct field into an ALU control code
  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: begin
        alu_op = ALU_ADD;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/unidad_control_mc.sv
// Multicycle control unit: walks each instruction through IF/ID/EX/MEM/WB,
// produces Moore control strobes and counts retired instructions.
// Optional feature macro: UNIDAD_CONTROL_TRAP_EN (illegal opcodes park the
// FSM in TRAP until reset instead of being treated as NOPs).
module unidad_control_mc
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             br_we,
  output logic [3:0]       alu_op,
  output logic             mux_sel,
  output logic             mem_w,
  output logic             mem_r,
  output logic [2:0]       estado,
  output logic [CNT_W-1:0] retired,
  output logic             trap
);

  state_t           state_q;
  state_t           state_d;
  class_t           class_q;
  class_t           class_d;
  class_t           id_class;
  logic             hold_q;
  logic             retire;
  logic [CNT_W-1:0] retired_q;
  logic [3:0]       dec_alu_op;
  logic             dec_valid;

  assign id_class = decode_class(opcode);

  decod_alu u_decod_alu (
    .funct  (funct),
    .alu_op (dec_alu_op),
    .valid  (dec_valid)
  );

  // State/class registers; hold_q blanks the first cycle after reset so
  // no strobe escapes while the reset is still being released
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      class_q <= CL_NONE;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      hold_q  <= 1'b0;
    end
  end

  // Next-state logic, class latch in ID and the retire pulse on exit
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    retire  = 1'b0;
    if (!hold_q) begin
      case (state_q)
        S_IF: state_d = S_ID;
        S_ID: begin
          class_d = id_class;
          case (id_class)
            CL_RTYPE, CL_LW, CL_SW: state_d = S_EX;
            default: begin
`ifdef UNIDAD_CONTROL_TRAP_EN
              state_d = S_TRAP;
`else
              state_d = S_IF;
              retire  = 1'b1;
`endif
            end
          endcase
        end
        S_EX: begin
          case (class_q)
            CL_RTYPE:     state_d = S_WB;
            CL_LW, CL_SW: state_d = S_MEM;
            default:      state_d = S_IF;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (class_q == CL_LW) begin
              state_d = S_WB;
            end else begin
              state_d = S_IF;
              retire  = 1'b1;
            end
          end
        end
        S_WB: begin
          state_d = S_IF;
          retire  = 1'b1;
        end
`ifdef UNIDAD_CONTROL_TRAP_EN
        S_TRAP: state_d = S_TRAP;
`endif
        default: state_d = S_IF;
      endcase
    end
  end

  // Moore output decode from the state register and the latched class
  always_comb begin
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    br_we   = 1'b0;
    alu_op  = 4'b0000;
    mux_sel = 1'b0;
    mem_w   = 1'b0;
    mem_r   = 1'b0;
    if (!hold_q) begin
      case (state_q)
        S_IF: begin
          pc_we = 1'b1;
          ir_we = 1'b1;
        end
        S_EX: begin
          alu_op = (class_q == CL_RTYPE) ? dec_alu_op : ALU_ADD;
        end
        S_MEM: begin
          mem_w = (class_q == CL_SW);
          mem_r = (class_q == CL_LW);
        end
        S_WB: begin
          if (class_q == CL_RTYPE) begin
            br_we = dec_valid;
          end else if (class_q == CL_LW) begin
            br_we   = 1'b1;
            mux_sel = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 1'b1;
    end
  end

`ifdef UNIDAD_CONTROL_TRAP_EN
  logic trap_q;

  // Sticky trap flag, raised on entry into TRAP and cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else if (state_d == S_TRAP) begin
      trap_q <= 1'b1;
    end
  end

  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  assign estado  = state_q;
  assign retired = retired_q;

endmodule
